// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// RV32I load/store FUNCT3 encodings and the access-size decode.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_NONE} size_t;

  // Stores only accept the signed encodings; SZ_NONE marks an illegal FUNCT3.
  function automatic size_t access_size(input logic write, input logic [2:0] funct3);
    size_t sz;
    sz = SZ_NONE;
    if (write) begin
      case (funct3)
        F3_B:    sz = SZ_BYTE;
        F3_H:    sz = SZ_HALF;
        F3_W:    sz = SZ_WORD;
        default: sz = SZ_NONE;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_BU: sz = SZ_BYTE;
        F3_H, F3_HU: sz = SZ_HALF;
        F3_W:        sz = SZ_WORD;
        default:     sz = SZ_NONE;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage (master) and the responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder_lane_align.sv
// Combinational byte-lane steering: store byte enables and replicated write
// data, load lane selection with sign/zero extension, and error detection.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] raw,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        err
);

  size_t      size;
  logic [7:0] b;
  logic [15:0] h;

  always_comb begin
    size  = access_size(write, funct3);
    b     = raw[{addr, 3'b000} +: 8];
    h     = addr[1] ? raw[31:16] : raw[15:0];
    be    = '0;
    wword = wdata;
    rdata = '0;
    err   = 1'b0;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << addr;
        wword = {4{wdata[7:0]}};
        rdata = funct3[2] ? {24'h0, b} : {{24{b[7]}}, b};
      end
      SZ_HALF: begin
        err   = addr[0];
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rdata = funct3[2] ? {16'h0, h} : {{16{h[15]}}, h};
      end
      SZ_WORD: begin
        err   = (addr != 2'b00);
        be    = '1;
        rdata = raw;
      end
      default: err = 1'b1;
    endcase
    // Errors never touch the RAM; stores and errors always return zero data.
    if (err || !write) be = '0;
    if (err || write) rdata = '0;
  end

endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data RAM behind an IDLE/WAIT/RESP responder with LATENCY
// wait states; commits on the edge entering RESP and pulses a one-cycle response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input logic              clk,
  input logic              reset,
  dmem_responder_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            ready_q;
  logic            rsp_valid_q;
  logic [31:0]     rsp_rdata_q;
  logic            rsp_err_q;

  logic            write_q;
  logic [2:0]      f3_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;

  logic            a_write;
  logic [2:0]      a_f3;
  logic [AW+1:0]   a_addr;
  logic [31:0]     a_wdata;
  logic [31:0]     raw;
  logic [3:0]      be;
  logic [31:0]     wword;
  logic [31:0]     ext;
  logic            err;
  logic            commit;
  logic            unused_addr;

  logic [31:0]     mem [DEPTH];

  // With zero wait states the commit happens on the accept edge itself, so the
  // lane logic must see the live request while IDLE rather than the latched copy.
  always_comb begin
    if (state == IDLE) begin
      a_write = bus.req_write;
      a_f3    = bus.req_funct3;
      a_addr  = bus.req_addr[AW+1:0];
      a_wdata = bus.req_wdata;
    end else begin
      a_write = write_q;
      a_f3    = f3_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
    end
  end

  assign raw         = mem[a_addr[AW+1:2]];
  assign commit      = ((state == IDLE) && bus.req_valid && (LATENCY == 0)) ||
                       ((state == WAIT) && (cnt == '0));
  assign unused_addr = ^bus.req_addr[31:AW+2];

  dmem_lane_align u_align (
    .write  (a_write),
    .funct3 (a_f3),
    .addr   (a_addr[1:0]),
    .wdata  (a_wdata),
    .raw    (raw),
    .be     (be),
    .wword  (wword),
    .rdata  (ext),
    .err    (err)
  );

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[a_addr[AW+1:2]][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      write_q     <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            write_q <= bus.req_write;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr[AW+1:0];
            wdata_q <= bus.req_wdata;
            ready_q <= 1'b0;
            if (LATENCY == 0) begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= ext;
              rsp_err_q   <= err;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= ext;
            rsp_err_q   <= err;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state       <= IDLE;
          ready_q     <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (LATENCY 0 and 2) checked
// against a byte-addressed reference memory model.
module tb_dmem_responder;
  import dmem_pkg::*;

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n     [2];
  logic        req_valid [2];
  logic        req_write [2];
  logic [2:0]  req_f3    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        ready     [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  logic [7:0]  mem_m [2][4096];
  exp_t        q0[$];
  exp_t        q1[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();

  assign bus0.req_valid  = req_valid[0];
  assign bus0.req_write  = req_write[0];
  assign bus0.req_funct3 = req_f3[0];
  assign bus0.req_addr   = req_addr[0];
  assign bus0.req_wdata  = req_wdata[0];
  assign ready[0]        = bus0.req_ready;
  assign rsp_valid[0]    = bus0.rsp_valid;
  assign rsp_rdata[0]    = bus0.rsp_rdata;
  assign rsp_err[0]      = bus0.rsp_err;

  assign bus1.req_valid  = req_valid[1];
  assign bus1.req_write  = req_write[1];
  assign bus1.req_funct3 = req_f3[1];
  assign bus1.req_addr   = req_addr[1];
  assign bus1.req_wdata  = req_wdata[1];
  assign ready[1]        = bus1.req_ready;
  assign rsp_valid[1]    = bus1.rsp_valid;
  assign rsp_rdata[1]    = bus1.rsp_rdata;
  assign rsp_err[1]      = bus1.rsp_err;

  dmem_responder #(.DEPTH(1024), .LATENCY(0)) dut0 (.clk(clk), .reset(rst_n[0]), .bus(bus0));
  dmem_responder #(.DEPTH(1024), .LATENCY(2)) dut1 (.clk(clk), .reset(rst_n[1]), .bus(bus1));

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: a flat byte array; access width and signedness from the RV32I table.
  function automatic void model(input int i, input bit w, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd, input bit commit,
                                output logic [31:0] rd, output logic er);
    int n;
    bit sgn;
    int base;
    longint unsigned v;
    n = 0;
    sgn = 1'b0;
    rd = '0;
    if (w) begin
      case (f3)
        3'd0: n = 1;
        3'd1: n = 2;
        3'd2: n = 4;
        default: n = 0;
      endcase
    end else begin
      case (f3)
        3'd0: begin n = 1; sgn = 1'b1; end
        3'd1: begin n = 2; sgn = 1'b1; end
        3'd2: n = 4;
        3'd4: n = 1;
        3'd5: n = 2;
        default: n = 0;
      endcase
    end
    er = (n == 0) ? 1'b1 : ((a % n) != 0);
    if (er) return;
    base = int'(a % 32'd4096);
    if (w) begin
      if (commit) for (int k = 0; k < n; k++) mem_m[i][base + k] = wd[8*k +: 8];
    end else begin
      v = 0;
      for (int k = 0; k < n; k++) v = v | (64'(mem_m[i][base + k]) << (8 * k));
      if (sgn && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
      rd = v[31:0];
    end
  endfunction

  task automatic issue(input int i, input bit w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit expect_rsp, input bit chk_ready);
    exp_t e;
    int   lat;
    bit   got;
    lat = (i == 0) ? 0 : 2;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = ready[i];
    end
    check32("ready_wait", {31'b0, got}, 32'd1);
    if (!got) return;
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_f3[i]    = f3;
    req_addr[i]  = a;
    req_wdata[i] = wd;
    model(i, w, f3, a, wd, expect_rsp, e.rd, e.er);
    e.due = cyc + 1 + lat;
    if (expect_rsp) begin
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
    req_write[i] = 1'($urandom);
    req_f3[i]    = 3'($urandom);
    req_addr[i]  = $urandom;
    req_wdata[i] = $urandom;
    if (chk_ready) begin
      for (int t = 0; t <= lat; t++) begin
        @(negedge clk);
        check32("ready_busy", {31'b0, ready[i]}, 32'd0);
      end
      @(negedge clk);
      check32("ready_idle", {31'b0, ready[i]}, 32'd1);
    end
  endtask

  task automatic mon(input int i);
    exp_t e;
    int   sz;
    sz = (i == 0) ? q0.size() : q1.size();
    if (rsp_valid[i]) begin
      if (sz == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp inst%0d: got rsp_valid=1 expected 0 (t=%0t)", i, $time);
      end else begin
        if (i == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check32("rsp_rdata", rsp_rdata[i], e.rd);
        check32("rsp_err", {31'b0, rsp_err[i]}, {31'b0, e.er});
        check32("rsp_cycle", cyc, e.due);
      end
    end else if (sz != 0) begin
      e = (i == 0) ? q0[0] : q1[0];
      if (e.due < cyc) begin
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
        n_checks++;
        n_fail++;
        $display("FAIL rsp_timeout inst%0d: got no response expected one at cycle %0d", i, e.due);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected $finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_write[i] = 1'b0;
      req_f3[i] = '0; req_addr[i] = '0; req_wdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check32("reset_ready", {31'b0, ready[i]}, 32'd1);
      check32("reset_valid", {31'b0, rsp_valid[i]}, 32'd0);
      check32("reset_rdata", rsp_rdata[i], 32'd0);
      check32("reset_err", {31'b0, rsp_err[i]}, 32'd0);
      rst_n[i] = 1'b1;
    end

    for (int i = 0; i < 2; i++) begin
      issue(i, 1, F3_W, 32'h40, 32'hDEADBEEF, 1, 1);
      issue(i, 0, F3_W, 32'h40, 32'h0, 1, 1);
      issue(i, 1, F3_W, 32'h10, 32'h80FF7F01, 1, 1);
      issue(i, 0, F3_B, 32'h13, 32'h0, 1, 1);
      issue(i, 0, F3_BU, 32'h13, 32'h0, 1, 1);
      issue(i, 0, F3_H, 32'h12, 32'h0, 1, 1);
      issue(i, 0, F3_HU, 32'h10, 32'h0, 1, 1);
      issue(i, 1, F3_W, 32'h8, 32'h0, 1, 1);
      issue(i, 1, F3_B, 32'h9, 32'h000000AB, 1, 1);
      issue(i, 1, F3_H, 32'hA, 32'h00001234, 1, 1);
      issue(i, 0, F3_W, 32'h8, 32'h0, 1, 1);
      issue(i, 1, F3_H, 32'h21, 32'h5555AAAA, 1, 1);
      issue(i, 0, F3_W, 32'h22, 32'h0, 1, 1);
      issue(i, 0, 3'b011, 32'h8, 32'h0, 1, 1);
      issue(i, 1, 3'b100, 32'h8, 32'hFFFFFFFF, 1, 1);
      issue(i, 0, F3_W, 32'h8, 32'h0, 1, 1);
      issue(i, 1, F3_W, 32'h1000, 32'hCAFEF00D, 1, 1);
      issue(i, 0, F3_W, 32'h0, 32'h0, 1, 1);
    end

    issue(1, 1, F3_W, 32'h20, 32'h11111111, 1, 1);
    issue(1, 1, F3_W, 32'h20, 32'h22222222, 0, 0);
    @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    check32("abort_ready", {31'b0, ready[1]}, 32'd1);
    check32("abort_valid", {31'b0, rsp_valid[1]}, 32'd0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    repeat (4) @(negedge clk);
    issue(1, 0, F3_W, 32'h20, 32'h0, 1, 1);

    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 16; k++) issue(i, 1, F3_W, 32'(4 * k), $urandom, 1, 0);
      for (int k = 0; k < 150; k++) begin
        issue(i, 1'($urandom), 3'($urandom),
              32'($urandom_range(0, 63)) | (32'($urandom_range(0, 3)) << 12),
              $urandom, 1, ($urandom_range(0, 3) == 0));
      end
    end

    repeat (10) @(negedge clk);
    check32("sb_drain", 32'(q0.size() + q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
